// File: rtl/cache_prof_pkg.sv
// rtl/cache_prof_pkg.sv - shared types and constants for the cache profiler controller
package cache_prof_pkg;

  localparam int NUM_CNT_DEF = 8;
  localparam int CNT_W_DEF   = 32;
  localparam int ADDR_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DONE
  } ctrl_state_e;

  localparam int ADDR_SNAP0   = 0;
  localparam int ADDR_ELAPSED = 8;
  localparam int ADDR_STATUS  = 9;
  localparam int ADDR_WINDOW  = 10;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_VALID = 1;
  localparam int STAT_EARLY = 2;
  localparam int STAT_SAT   = 3;
  localparam int STAT_CONT  = 4;

endpackage

// File: rtl/prof_snapshot_regs.sv
// rtl/prof_snapshot_regs.sv - shadow registers for counter/elapsed snapshots with a registered read mux
module prof_snapshot_regs
  import cache_prof_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic [CNT_W-1:0]         elapsed_in,
  input  logic [CNT_W-1:0]         status_word,
  input  logic [CNT_W-1:0]         window_word,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     rd_valid
);

  // Entry NUM_CNT holds the elapsed cycle count of the captured window.
  logic [CNT_W-1:0]  shadow [NUM_CNT+1];
  logic [CNT_W-1:0]  rd_mux;
  logic [ADDR_W-1:0] snap_idx;

  assign snap_idx = rd_addr - ADDR_W'(ADDR_SNAP0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NUM_CNT; i++) shadow[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= cnt_in[i*CNT_W +: CNT_W];
      shadow[NUM_CNT] <= elapsed_in;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (int'(snap_idx) < NUM_CNT && int'(rd_addr) >= ADDR_SNAP0)
      rd_mux = shadow[snap_idx];
    else if (rd_addr == ADDR_W'(ADDR_ELAPSED))
      rd_mux = shadow[NUM_CNT];
    else if (rd_addr == ADDR_W'(ADDR_STATUS))
      rd_mux = status_word;
    else if (rd_addr == ADDR_W'(ADDR_WINDOW))
      rd_mux = window_word;
  end

  // Registered read sees register values from before any same-edge capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: rtl/cache_profiler_ctrl.sv
// rtl/cache_profiler_ctrl.sv - measurement window sequencer and snapshot read port for the cache profiler
module cache_profiler_ctrl
  import cache_prof_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [CNT_W-1:0]         window_len,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  output logic                     prof_enable,
  output logic                     busy,
  output logic                     done_pulse,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     rd_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e      state, next_state;
  logic [CNT_W-1:0] latched_len, elapsed, snap_elapsed, status_word;
  logic             cont_latched, snapshot_valid, stopped_early, elapsed_sat;
  logic             terminal, capture;

  assign terminal     = stop || ((latched_len != '0) && (elapsed == latched_len - CNT_W'(1)));
  assign snap_elapsed = (elapsed == CNT_MAX) ? CNT_MAX : elapsed + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    prof_enable = 1'b0;
    busy        = 1'b0;
    capture     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) next_state = ST_CLEAR;
      end
      // Enable held low for one cycle so the profiler starts from zero.
      ST_CLEAR: begin
        busy       = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        prof_enable = 1'b1;
        busy        = 1'b1;
        if (terminal) begin
          capture    = 1'b1;
          next_state = (cont_latched && !stop) ? ST_CLEAR : ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latched_len    <= '0;
      cont_latched   <= 1'b0;
      snapshot_valid <= 1'b0;
      stopped_early  <= 1'b0;
      elapsed_sat    <= 1'b0;
      elapsed        <= '0;
      done_pulse     <= 1'b0;
    end else begin
      done_pulse <= capture;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            latched_len    <= window_len;
            cont_latched   <= continuous && (window_len != '0);
            snapshot_valid <= 1'b0;
            stopped_early  <= 1'b0;
            elapsed_sat    <= 1'b0;
          end
        end
        ST_CLEAR: elapsed <= '0;
        ST_RUN: begin
          if (elapsed == CNT_MAX) elapsed_sat <= 1'b1;
          else                    elapsed     <= elapsed + CNT_W'(1);
          if (capture) begin
            snapshot_valid <= 1'b1;
            stopped_early  <= stop;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status_word             = '0;
    status_word[STAT_BUSY]  = busy;
    status_word[STAT_VALID] = snapshot_valid;
    status_word[STAT_EARLY] = stopped_early;
    status_word[STAT_SAT]   = elapsed_sat;
    status_word[STAT_CONT]  = cont_latched;
  end

  prof_snapshot_regs #(
    .NUM_CNT(NUM_CNT),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_snap (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .cnt_in     (cnt_in),
    .elapsed_in (snap_elapsed),
    .status_word(status_word),
    .window_word(latched_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

endmodule

// File: tb/tb_cache_profiler_ctrl.sv
// tb/tb_cache_profiler_ctrl.sv - self-checking bench for cache_profiler_ctrl
module tb_cache_profiler_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, stop, continuous, rd_en;
  logic [31:0]  window_len;
  logic [255:0] cnt_in;
  logic [3:0]   rd_addr;
  logic         prof_enable, busy, done_pulse, rd_valid;
  logic [31:0]  rd_data;

  // Narrow instance so elapsed saturation is reachable in a few cycles.
  logic         s_start, s_stop, s_cont, s_rd_en;
  logic [5:0]   s_len;
  logic [47:0]  s_cnt;
  logic [3:0]   s_rd_addr;
  logic         s_pe, s_busy, s_done, s_rd_valid;
  logic [5:0]   s_rd_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_snap [8];

  always #5 clk = ~clk;

  cache_profiler_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .window_len(window_len), .cnt_in(cnt_in), .prof_enable(prof_enable), .busy(busy),
    .done_pulse(done_pulse), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  cache_profiler_ctrl #(.NUM_CNT(8), .CNT_W(6), .ADDR_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .continuous(s_cont),
    .window_len(s_len), .cnt_in(s_cnt), .prof_enable(s_pe), .busy(s_busy),
    .done_pulse(s_done), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid)
  );

  typedef struct {
    int          n;
    bit          cont;
    int          t_stop;
    int          min_cyc;
    int          rd_cyc;
    logic [31:0] exp_el;
    logic [31:0] exp_st;
    int          exp_pulses;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic rd_read(input logic [3:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    d = rd_data;
  endtask

  task automatic s_read(input logic [3:0] a, output logic [31:0] d);
    s_rd_en = 1'b1; s_rd_addr = a;
    @(negedge clk);
    s_rd_en = 1'b0;
    chk("s_rd_valid", 32'(s_rd_valid), 32'd1);
    d = 32'(s_rd_data);
  endtask

  // Window timeline from cycle c=0 (the clear cycle after start):
  // continuous windows repeat with period n+1, run cycle index = c mod (n+1), 0 = clear.
  task automatic scenario(input int n, input bit cont, input int t_stop, input int min_cyc,
                          input int rd_cyc, output logic [31:0] el_rd,
                          output logic [31:0] st_rd, output int seen);
    bit cont_eff = cont && (n != 0);
    bit ended = 0, cap = 0, prev_cap = 0, rd_pend = 0, do_stop = 0, early = 0;
    int rp = 0, exp_pulses = 0, exp_el = 0;
    logic [31:0] rd_exp = '0, d;
    seen = 0;
    window_len = 32'(n); continuous = cont; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < min_cyc + n + 30; c++) begin
      if (!ended) rp = cont_eff ? c % (n + 1) : c;
      chk("prof_enable", 32'(prof_enable), 32'(!ended && rp != 0));
      chk("busy", 32'(busy), 32'(!ended));
      chk("done_pulse", 32'(done_pulse), 32'(prev_cap));
      seen += int'(done_pulse);
      if (rd_pend) begin
        chk("rd_on_capture", rd_data, rd_exp);
        rd_pend = 0;
      end
      if (ended) begin
        start = 1'b0; stop = 1'b0; rd_en = 1'b0;
        break;
      end
      for (int i = 0; i < 8; i++) cnt_in[i*32 +: 32] = $urandom;
      do_stop    = (c == t_stop) || (c >= min_cyc && rp != 0);
      stop       = do_stop;
      start      = ($urandom_range(0, 4) == 0);
      window_len = $urandom;
      continuous = 1'($urandom_range(0, 1));
      rd_en      = (c == rd_cyc);
      rd_addr    = 4'd1;
      if (c == rd_cyc) begin
        rd_exp  = exp_snap[1];
        rd_pend = 1;
      end
      cap = (rp != 0) && ((n != 0 && rp == n) || do_stop);
      if (cap) begin
        for (int i = 0; i < 8; i++) exp_snap[i] = cnt_in[i*32 +: 32];
        exp_el = rp;
        early  = do_stop;
        exp_pulses++;
        ended  = !cont_eff || do_stop;
      end
      prev_cap = cap;
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; rd_en = 1'b0;
    chk("scenario_ended", 32'(ended), 32'd1);
    for (int k = 0; k < 3; k++) begin
      stop = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("done_stop_ignored", 32'(prof_enable), 32'd0);
      chk("done_no_pulse", 32'(done_pulse), 32'd0);
    end
    stop = 1'b0;
    chk("pulse_count", 32'(seen), 32'(exp_pulses));
    for (int a = 0; a < 8; a++) begin
      rd_read(4'(a), d);
      chk("snapshot", d, exp_snap[a]);
    end
    rd_read(4'd8, el_rd);
    chk("elapsed", el_rd, 32'(exp_el));
    rd_read(4'd9, st_rd);
    chk("status", st_rd, {27'b0, cont_eff, 1'b0, early, 1'b1, 1'b0});
    rd_read(4'd10, d);
    chk("window", d, 32'(n));
    rd_read(4'($urandom_range(11, 15)), d);
    chk("unmapped", d, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    int          sk [4];
    logic [31:0] d, el, st;
    int          seen;

    tbl[0] = '{100,  1'b0, -1, 500, 50, 32'd100, 32'h02, 1};
    tbl[1] = '{1000, 1'b0, 37, 500, -1, 32'd37,  32'h06, 1};
    tbl[2] = '{10,   1'b1, 40, 500, -1, 32'd7,   32'h16, 4};
    tbl[3] = '{8,    1'b0, 8,  500, 8,  32'd8,   32'h06, 1};
    tbl[4] = '{1,    1'b0, -1, 500, -1, 32'd1,   32'h02, 1};
    tbl[5] = '{0,    1'b1, 20, 500, -1, 32'd20,  32'h06, 1};
    tbl[6] = '{3,    1'b1, 4,  9,   -1, 32'd1,   32'h16, 3};
    sk = '{20, 63, 64, 100};

    for (int i = 0; i < 8; i++) exp_snap[i] = '0;
    rst = 1'b1; start = 0; stop = 0; continuous = 0; rd_en = 0; rd_addr = '0;
    window_len = '0; cnt_in = '0;
    s_start = 0; s_stop = 0; s_cont = 0; s_rd_en = 0; s_rd_addr = '0; s_len = '0; s_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset_pe", 32'(prof_enable), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done_pulse), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 11; a++) begin
      rd_read(4'(a), d);
      chk("reset_read", d, 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      scenario(tbl[v].n, tbl[v].cont, tbl[v].t_stop, tbl[v].min_cyc, tbl[v].rd_cyc, el, st, seen);
      chk("tbl_elapsed", el, tbl[v].exp_el);
      chk("tbl_status", st, tbl[v].exp_st);
      chk("tbl_pulses", 32'(seen), 32'(tbl[v].exp_pulses));
    end

    for (int r = 0; r < 8; r++) begin
      scenario(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 80)) : -1,
               int'($urandom_range(10, 90)), int'($urandom_range(0, 60)), el, st, seen);
    end

    for (int j = 0; j < 4; j++) begin
      s_cnt = {$urandom, 16'($urandom)};
      s_len = '0; s_cont = 1'b1; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (sk[j]) @(negedge clk);
      s_stop = 1'b1;
      @(negedge clk);
      s_stop = 1'b0;
      chk("sat_done_pulse", 32'(s_done), 32'd1);
      s_read(4'd8, d);
      chk("sat_elapsed", d, 32'((sk[j] > 63) ? 63 : sk[j]));
      s_read(4'd9, d);
      chk("sat_status", d, 32'h06 | ((sk[j] > 63) ? 32'h08 : 32'h00));
      s_read(4'd0, d);
      chk("sat_snap0", d, 32'(s_cnt[5:0]));
    end

    window_len = 32'd50; continuous = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_pe", 32'(prof_enable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_pe", 32'(prof_enable), 32'd0);
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done_pulse), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_snap[i] = '0;
    @(negedge clk);
    chk("post_reset_idle_pe", 32'(prof_enable), 32'd0);
    chk("post_reset_done", 32'(done_pulse), 32'd0);
    for (int a = 0; a < 11; a++) begin
      rd_read(4'(a), d);
      chk("post_reset_read", d, 32'd0);
      chk("post_reset_no_pulse", 32'(done_pulse), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_profiler_ctrl.md
Name: cache_profiler_ctrl

Overview:
Sequencer for the cache profiling unit. It drives the profiler's enable line to clear, run and stop a measurement window. At window end it captures the eight cache counters and the elapsed cycle count into shadow registers, then exposes them through a registered read port for the host/debug bus. It sits between the host control path and the cache profiler, which zeroes its counters whenever its enable input is low.

Parameters:
NUM_CNT, 8, number of profiler counters snapshotted; fixed order: icache hit, miss, request, dcache hit, miss, request, icache fill latency, dcache fill latency
CNT_W, 32, width of each counter, window length and elapsed count
ADDR_W, 4, read address width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  pulse; begin a measurement window (honoured in IDLE/DONE only)
stop  in  1  pulse; end the current window early (honoured in RUN only)
continuous  in  1  sampled at start; 1 = re-arm automatically after each bounded window
window_len  in  CNT_W  cycles per window, sampled at start; 0 = unbounded (runs until stop)
cnt_in  in  NUM_CNT*CNT_W  live profiler counter values, counter 0 in LSBs
prof_enable  out  1  drives the profiler enable input
busy  out  1  high in CLEAR or RUN
done_pulse  out  1  one-cycle pulse on every snapshot capture
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  0..7 snapshot counter, 8 elapsed, 9 status, 10 latched window_len, others read 0
rd_data  out  CNT_W  registered read data
rd_valid  out  1  high the cycle after rd_en

Behaviour:
- Reset: state=IDLE; prof_enable, busy, done_pulse, rd_valid=0; rd_data, snapshots, elapsed, latched window/mode=0; all status bits 0.
- States: IDLE, CLEAR, RUN, DONE (enum in package).
- IDLE/DONE + start: latch window_len and continuous (continuous forced 0 if window_len==0); clear snapshot_valid, stopped_early, elapsed_sat; go to CLEAR. stop is ignored.
- CLEAR: exactly one cycle with prof_enable=0, which guarantees the profiler counters are zero. elapsed<=0. Go to RUN.
- RUN: prof_enable=1. elapsed increments each cycle and saturates at all-ones; on saturation set sticky elapsed_sat. start is ignored.
- Terminal condition in RUN: stop, or (latched_len!=0 and elapsed==latched_len-1).
  - On the terminal edge: snapshot[i]<=cnt_in[i]; snap_elapsed<=elapsed+1 (saturating); snapshot_valid<=1; done_pulse=1 in the following cycle.
  - Bounded window of N therefore spends exactly N cycles in RUN.
- Next state after the terminal edge: CLEAR if continuous and not stop; otherwise DONE.
  - stop during a continuous run ends the run: DONE, stopped_early=1.
- stop coincident with terminal count: single capture, goes to DONE, stopped_early=1.
- Re-arm capture: snapshot_valid is NOT cleared on a continuous re-arm; the snapshot holds the last completed window until the next capture.
- DONE: prof_enable=0 (profiler counters clear); snapshots hold.
- Read port:
  - rd_data/rd_valid registered, latency 1.
  - A read in the same cycle as a capture edge returns the pre-capture value.
  - Status word: bit0 busy, bit1 snapshot_valid, bit2 stopped_early, bit3 elapsed_sat, bit4 continuous_latched, upper bits 0.
- Reset mid-run: immediate return to IDLE next edge; prof_enable low; no capture; no done_pulse.
- Arithmetic: all comparisons unsigned CNT_W; no counter ever wraps.

Decomposition:
- Package cache_prof_pkg: ctrl state enum; read address constants (ADDR_SNAP0=0, ADDR_ELAPSED=8, ADDR_STATUS=9, ADDR_WINDOW=10); status bit indices; NUM_CNT/CNT_W defaults.
- One sub-module, prof_snapshot_regs: NUM_CNT+1 shadow registers with a capture strobe and registered read mux.
- The FSM and elapsed counter stay in the top level.

Test Plan:
- Bounded window: window_len=100, start, cnt_in[1] ramps → prof_enable high exactly 100 cycles; done_pulse once; addr8 reads 100; addr1 equals cnt_in[1] at terminal edge; status=0x2.
- Early stop: window_len=1000, stop at RUN cycle 37 → DONE; addr8 reads 37; status=0x6; later stop pulses ignored.
- Unbounded + saturation: window_len=0, force elapsed to 0xFFFFFFF0, run 32 cycles, stop → addr8=0xFFFFFFFF; status bit3 set.
- Continuous: window_len=10, continuous=1 → one CLEAR cycle (prof_enable=0) between windows; done_pulse every 11 cycles; stop → DONE, stopped_early=1.
- Boundaries: stop coincident with terminal count → one done_pulse; read addr1 on the capture cycle → old value; start in RUN ignored.
- Reset at RUN cycle 5 → next cycle prof_enable=0, state IDLE, all reads 0, no done_pulse.
